// File: rtl/lut_table_writer_pkg.sv
// Shared types for the lut_table_writer slice: request opcodes, response
// status codes, control FSM states and a slot-index width helper.
package lut_pkg;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_DELETE = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_COMMIT = 2'd3
    } lut_op_e;

    typedef enum logic [1:0] {
        ST_OK_NEW    = 2'd0,
        ST_OK_UPDATE = 2'd1,
        ST_MISS      = 2'd2,
        ST_FULL      = 2'd3
    } lut_status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } lut_state_e;

    // A single-slot table still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_slot_search.sv
// Combinational slot search: finds the valid slot holding a key and the
// lowest-numbered free slot.
module lut_slot_search
    import lut_pkg::*;
#(
    parameter  int unsigned NR_KEY  = 2,
    parameter  int unsigned KEY_LEN = 1,
    localparam int unsigned IDX_W   = idx_width(NR_KEY)
) (
    input  logic [NR_KEY*KEY_LEN-1:0] keys,
    input  logic [NR_KEY-1:0]         valid_mask,
    input  logic [KEY_LEN-1:0]        search_key,
    output logic                      hit,
    output logic [IDX_W-1:0]          hit_idx,
    output logic                      free,
    output logic [IDX_W-1:0]          free_idx
);

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            if (!hit && valid_mask[i] && (keys[i*KEY_LEN +: KEY_LEN] == search_key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!free && !valid_mask[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lut_table_writer.sv
// Key/data table builder driving the packed lut bus of General_Multiplexier.
// Define LUT_WRITER_SHADOW_EN to edit a shadow table published only on COMMIT.
module lut_table_writer
    import lut_pkg::*;
#(
    parameter  int unsigned         NR_KEY   = 2,
    parameter  int unsigned         KEY_LEN  = 1,
    parameter  int unsigned         DATA_LEN = 1,
    parameter  logic [KEY_LEN-1:0]  FILL_KEY = '0,
    localparam int unsigned         IDX_W    = idx_width(NR_KEY),
    localparam int unsigned         CNT_W    = $clog2(NR_KEY + 1),
    localparam int unsigned         PAIR_LEN = KEY_LEN + DATA_LEN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_op,
    input  logic [KEY_LEN-1:0]         req_key,
    input  logic [DATA_LEN-1:0]        req_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [1:0]                 resp_status,
    output logic [IDX_W-1:0]           resp_index,
    output logic [NR_KEY*PAIR_LEN-1:0] lut,
    output logic [NR_KEY-1:0]          valid_mask,
    output logic [CNT_W-1:0]           count
);

    lut_state_e            r_state;
    lut_state_e            w_state_next;
    lut_op_e               r_op;
    logic [KEY_LEN-1:0]    r_key;
    logic [DATA_LEN-1:0]   r_data;
    lut_status_e           r_status;
    logic [IDX_W-1:0]      r_index;

    // Working copy: the table that requests search and modify.
    logic [KEY_LEN-1:0]    r_wkey  [NR_KEY];
    logic [DATA_LEN-1:0]   r_wdata [NR_KEY];
    logic [NR_KEY-1:0]     r_wvalid;

    // Live copy: the table seen on lut/valid_mask/count.
    logic [KEY_LEN-1:0]    w_lkey  [NR_KEY];
    logic [DATA_LEN-1:0]   w_ldata [NR_KEY];
    logic [NR_KEY-1:0]     w_lvalid;

    logic [NR_KEY*KEY_LEN-1:0] w_keys_packed;
    logic                      w_hit;
    logic [IDX_W-1:0]          w_hit_idx;
    logic                      w_free;
    logic [IDX_W-1:0]          w_free_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_next = S_EXEC;
            end
            S_EXEC: w_state_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= OP_INSERT;
            r_key  <= '0;
            r_data <= '0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_op   <= lut_op_e'(req_op);
            r_key  <= req_key;
            r_data <= req_data;
        end
    end

    always_comb begin
        w_keys_packed = '0;
        for (int unsigned i = 0; i < NR_KEY; i++)
            w_keys_packed[i*KEY_LEN +: KEY_LEN] = r_wkey[i];
    end

    lut_slot_search #(
        .NR_KEY  (NR_KEY),
        .KEY_LEN (KEY_LEN)
    ) u_search (
        .keys       (w_keys_packed),
        .valid_mask (r_wvalid),
        .search_key (r_key),
        .hit        (w_hit),
        .hit_idx    (w_hit_idx),
        .free       (w_free),
        .free_idx   (w_free_idx)
    );

    // Invalid slots are rewritten to {FILL_KEY, 0} so the lut never needs masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NR_KEY; i++) begin
                r_wkey[i]  <= FILL_KEY;
                r_wdata[i] <= '0;
            end
            r_wvalid <= '0;
            r_status <= ST_OK_NEW;
            r_index  <= '0;
        end else if (r_state == S_EXEC) begin
            r_status <= ST_OK_NEW;
            r_index  <= '0;
            case (r_op)
                OP_INSERT: begin
                    if (w_hit) begin
                        r_wdata[w_hit_idx] <= r_data;
                        r_status           <= ST_OK_UPDATE;
                        r_index            <= w_hit_idx;
                    end else if (w_free) begin
                        r_wkey[w_free_idx]   <= r_key;
                        r_wdata[w_free_idx]  <= r_data;
                        r_wvalid[w_free_idx] <= 1'b1;
                        r_index              <= w_free_idx;
                    end else begin
                        r_status <= ST_FULL;
                    end
                end
                OP_DELETE: begin
                    if (w_hit) begin
                        r_wkey[w_hit_idx]   <= FILL_KEY;
                        r_wdata[w_hit_idx]  <= '0;
                        r_wvalid[w_hit_idx] <= 1'b0;
                        r_index             <= w_hit_idx;
                    end else begin
                        r_status <= ST_MISS;
                    end
                end
                OP_CLEAR: begin
                    for (int unsigned i = 0; i < NR_KEY; i++) begin
                        r_wkey[i]  <= FILL_KEY;
                        r_wdata[i] <= '0;
                    end
                    r_wvalid <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef LUT_WRITER_SHADOW_EN
    logic [KEY_LEN-1:0]  r_lkey  [NR_KEY];
    logic [DATA_LEN-1:0] r_ldata [NR_KEY];
    logic [NR_KEY-1:0]   r_lvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NR_KEY; i++) begin
                r_lkey[i]  <= FILL_KEY;
                r_ldata[i] <= '0;
            end
            r_lvalid <= '0;
        end else if (r_state == S_EXEC && r_op == OP_COMMIT) begin
            r_lkey   <= r_wkey;
            r_ldata  <= r_wdata;
            r_lvalid <= r_wvalid;
        end
    end

    assign w_lkey   = r_lkey;
    assign w_ldata  = r_ldata;
    assign w_lvalid = r_lvalid;
`else
    assign w_lkey   = r_wkey;
    assign w_ldata  = r_wdata;
    assign w_lvalid = r_wvalid;
`endif

    always_comb begin
        lut   = '0;
        count = '0;
        for (int unsigned i = 0; i < NR_KEY; i++) begin
            lut[i*PAIR_LEN +: PAIR_LEN] = {w_lkey[i], w_ldata[i]};
            count = count + CNT_W'(w_lvalid[i]);
        end
    end

    assign valid_mask  = w_lvalid;
    assign resp_status = r_status;
    assign resp_index  = r_index;

endmodule

// File: tb/tb_lut_table_writer.sv
// Self-checking bench for lut_table_writer: directed vector table, handshake
// corner sequences and randomized traffic against a slot-table model.
module tb_lut_table_writer;

    localparam int unsigned NK = 4;
    localparam int unsigned KL = 4;
    localparam int unsigned DL = 8;
    localparam int unsigned PL = KL + DL;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [1:0]      req_op = '0;
    logic [KL-1:0]   req_key = '0;
    logic [DL-1:0]   req_data = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [1:0]      resp_status;
    logic [1:0]      resp_index;
    logic [NK*PL-1:0] lut;
    logic [NK-1:0]   valid_mask;
    logic [2:0]      count;

    always #5 clk = ~clk;

    lut_table_writer #(
        .NR_KEY   (NK),
        .KEY_LEN  (KL),
        .DATA_LEN (DL),
        .FILL_KEY (4'hF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_key     (req_key),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_index  (resp_index),
        .lut         (lut),
        .valid_mask  (valid_mask),
        .count       (count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: editable table (w*) and the published table (l*).
    logic [KL-1:0] wk [NK];
    logic [DL-1:0] wd [NK];
    bit            wv [NK];
    logic [KL-1:0] lk [NK];
    logic [DL-1:0] ld [NK];
    bit            lv [NK];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NK; i++) begin
            wv[i] = 0; wk[i] = '0; wd[i] = '0;
            lv[i] = 0; lk[i] = '0; ld[i] = '0;
        end
    endfunction

    function automatic void model_publish();
        for (int i = 0; i < NK; i++) begin
            lv[i] = wv[i]; lk[i] = wk[i]; ld[i] = wd[i];
        end
    endfunction

    function automatic void model_apply(input logic [1:0] op, input logic [KL-1:0] key,
                                        input logic [DL-1:0] data,
                                        output logic [1:0] st, output logic [1:0] idx);
        int h = -1;
        int f = -1;
        for (int i = 0; i < NK; i++) begin
            if (h < 0 && wv[i] && wk[i] == key) h = i;
            if (f < 0 && !wv[i]) f = i;
        end
        st = 2'd0;
        idx = 2'd0;
        case (op)
            2'd0: begin
                if (h >= 0) begin wd[h] = data; st = 2'd1; idx = 2'(h); end
                else if (f >= 0) begin wv[f] = 1; wk[f] = key; wd[f] = data; idx = 2'(f); end
                else st = 2'd3;
            end
            2'd1: begin
                if (h >= 0) begin wv[h] = 0; idx = 2'(h); end
                else st = 2'd2;
            end
            2'd2: for (int i = 0; i < NK; i++) wv[i] = 0;
            default: begin
`ifdef LUT_WRITER_SHADOW_EN
                model_publish();
`endif
            end
        endcase
`ifndef LUT_WRITER_SHADOW_EN
        model_publish();
`endif
    endfunction

    function automatic logic [NK*PL-1:0] exp_lut();
        logic [NK*PL-1:0] r = '0;
        for (int i = 0; i < NK; i++)
            r[i*PL +: PL] = lv[i] ? {lk[i], ld[i]} : 12'hF00;
        return r;
    endfunction

    function automatic logic [NK-1:0] exp_mask();
        logic [NK-1:0] m = '0;
        for (int i = 0; i < NK; i++) m[i] = lv[i];
        return m;
    endfunction

    function automatic int exp_count();
        int c = 0;
        for (int i = 0; i < NK; i++) c += lv[i] ? 1 : 0;
        return c;
    endfunction

    task automatic check_table(input string tag);
        check({tag, ".lut"}, lut, exp_lut());
        check({tag, ".mask"}, valid_mask, exp_mask());
        check({tag, ".count"}, count, exp_count());
    endtask

    // Wait for resp_valid; latency counted in negedges after the accept edge.
    task automatic wait_resp(input string tag, output logic [1:0] st, output logic [1:0] idx);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        st = resp_status;
        idx = resp_index;
        if (!resp_valid) timeout({tag, ".resp"});
        else begin
            check({tag, ".latency"}, n, 2);
            check({tag, ".req_ready_in_resp"}, req_ready, 1'b0);
        end
    endtask

    task automatic do_req(input string tag, input logic [1:0] op, input logic [KL-1:0] key,
                          input logic [DL-1:0] data,
                          output logic [1:0] st, output logic [1:0] idx);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_key = key; req_data = data;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            timeout({tag, ".accept"});
            req_valid = 1'b0;
            st = 2'd0; idx = 2'd0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(tag, st, idx);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [KL-1:0] key;
        logic [DL-1:0] data;
        logic [1:0]    st;
        logic [1:0]    idx;
    } vec_t;

    vec_t tbl [14];

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [1:0] st, idx, mst, midx, st0, idx0;
        logic [1:0] op;
        logic [KL-1:0] key;
        logic [DL-1:0] data;
        int r, n;

        // op: 0 INSERT 1 DELETE 2 CLEAR 3 COMMIT; st: 0 NEW 1 UPDATE 2 MISS 3 FULL
        tbl[0]  = '{2'd0, 4'h3, 8'hAA, 2'd0, 2'd0};
        tbl[1]  = '{2'd0, 4'h3, 8'h55, 2'd1, 2'd0};
        tbl[2]  = '{2'd0, 4'h5, 8'h11, 2'd0, 2'd1};
        tbl[3]  = '{2'd0, 4'h6, 8'h22, 2'd0, 2'd2};
        tbl[4]  = '{2'd0, 4'h1, 8'h33, 2'd0, 2'd3};
        tbl[5]  = '{2'd0, 4'h9, 8'h44, 2'd3, 2'd0};
        tbl[6]  = '{2'd1, 4'h7, 8'h00, 2'd2, 2'd0};
        tbl[7]  = '{2'd1, 4'h5, 8'h00, 2'd0, 2'd1};
        tbl[8]  = '{2'd0, 4'h8, 8'h66, 2'd0, 2'd1};
        tbl[9]  = '{2'd3, 4'h0, 8'h00, 2'd0, 2'd0};
        tbl[10] = '{2'd2, 4'h0, 8'h00, 2'd0, 2'd0};
        tbl[11] = '{2'd1, 4'h3, 8'h00, 2'd2, 2'd0};
        tbl[12] = '{2'd0, 4'h2, 8'h77, 2'd0, 2'd0};
        tbl[13] = '{2'd3, 4'h0, 8'h00, 2'd0, 2'd0};

        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.lut", lut, 48'hF00F00F00F00);
        check("reset.count", count, 0);
        check("reset.mask", valid_mask, 0);
        check("reset.req_ready", req_ready, 1);
        check("reset.resp_valid", resp_valid, 0);
        check("reset.resp_status", resp_status, 0);
        check("reset.resp_index", resp_index, 0);

        for (int i = 0; i < 14; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i].op, tbl[i].key, tbl[i].data, st, idx);
            model_apply(tbl[i].op, tbl[i].key, tbl[i].data, mst, midx);
            check($sformatf("vec%0d.status", i), st, tbl[i].st);
            check($sformatf("vec%0d.index", i), idx, tbl[i].idx);
            check_table($sformatf("vec%0d", i));
            if (i == 5) begin
`ifdef LUT_WRITER_SHADOW_EN
                check("full.lut_const", lut, 48'hF00F00F00F00);
`else
                check("full.lut_const", lut, 48'h133622511355);
`endif
            end
        end
        check("commit.lut_const", lut, 48'hF00F00F00277);

        // Back-pressure with a second request waiting behind the response.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_key = 4'h4; req_data = 8'h99;
        @(posedge clk);
        #1 req_key = 4'hA; req_data = 8'h12;
        model_apply(2'd0, 4'h4, 8'h99, mst, midx);
        wait_resp("bp.first", st0, idx0);
        check("bp.first.status", st0, mst);
        check("bp.first.index", idx0, midx);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp.hold%0d.resp_valid", c), resp_valid, 1);
            check($sformatf("bp.hold%0d.status", c), resp_status, st0);
            check($sformatf("bp.hold%0d.index", c), resp_index, idx0);
            check($sformatf("bp.hold%0d.req_ready", c), req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("bp.second.ready_after_hs", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("bp.second.exec_ready", req_ready, 0);
        check("bp.second.exec_resp_valid", resp_valid, 0);
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        if (!resp_valid) timeout("bp.second.resp");
        model_apply(2'd0, 4'hA, 8'h12, mst, midx);
        check("bp.second.status", resp_status, mst);
        check("bp.second.index", resp_index, midx);
        check_table("bp.second");
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;

        // Reset pulse while the request is in EXEC.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_key = 4'hC; req_data = 8'h5A;
        @(posedge clk);
        #2 rst_n = 1'b0;
        req_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_exec.c%0d.resp_valid", c), resp_valid, 0);
        end
        check("rst_exec.req_ready", req_ready, 1);
        check("rst_exec.lut", lut, 48'hF00F00F00F00);
        check_table("rst_exec");

        // Randomized traffic over a small key space to hit UPDATE/MISS/FULL.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            op = (r < 50) ? 2'd0 : (r < 80) ? 2'd1 : (r < 83) ? 2'd2 : 2'd3;
            key = 4'($urandom_range(0, 6));
            data = 8'($urandom);
            do_req($sformatf("rnd%0d", i), op, key, data, st, idx);
            model_apply(op, key, data, mst, midx);
            check($sformatf("rnd%0d.status", i), st, mst);
            check($sformatf("rnd%0d.index", i), idx, midx);
            check_table($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
